// File: rtl/nibble_serial_adder_if.sv
// Valid/ready operand and result channel for the nibble-serial adder.
// The master drives operands and result acceptance; the slave is the adder.
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Serial adder: one 4-bit carry-lookahead slice processes one nibble per cycle,
// so a W-bit add takes NIBBLES cycles between accept and result.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nibble_serial_adder_if.slave bus
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic             in_ready;
  logic             out_valid;
  logic             busy;
  logic             accept;
  logic             last_nib;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [5:0]       slice;

  // Returns {c3, c4, s[3:0]}; every carry is a flat sum of products of g/p and c0.
  function automatic logic [5:0] cla4(input logic [3:0] x,
                                      input logic [3:0] y,
                                      input logic       c0);
    logic [3:0] g;
    logic [3:0] p;
    logic       c1, c2, c3, c4;
    g  = x & y;
    p  = x ^ y;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
       | (p[2] & p[1] & p[0] & c0);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
       | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c3, c4, p ^ {c3, c2, c1, c0}};
  endfunction

  assign accept   = bus.in_valid && in_ready;
  assign last_nib = (idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = ADD;
      ADD:  if (last_nib) state_d = DONE;
      DONE: begin
        if (bus.out_ready) state_d = accept ? ADD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: in_ready = 1'b1;
      ADD:  busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = bus.out_ready;
      end
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx_q == IDX_W'(n)) begin
        a_nib = a_q[n*4 +: 4];
        b_nib = b_q[n*4 +: 4];
      end
    end
  end

  assign slice = cla4(a_nib, b_nib, carry_q);

  // Result fields change only inside ADD; in DONE they hold until released.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    if (state_q == ADD) begin
      for (int n = 0; n < NIBBLES; n++) begin
        if (idx_q == IDX_W'(n)) sum_d[n*4 +: 4] = slice[3:0];
      end
      carry_d = slice[4];
      idx_d   = idx_q + IDX_W'(1);
      if (last_nib) begin
        cout_d = slice[4];
        ovf_d  = slice[5] ^ slice[4];
      end
    end
    if (accept) begin
      a_d     = bus.a;
      b_d     = bus.b;
      carry_d = bus.cin;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  // Operand latches need no reset: they are only read after an accept.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the operand width W = 4*NIBBLES bits; legal range 2..8.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand set on a, b, cin is valid.
REQ-005 in_ready  output  1  block can accept an operand set this cycle.
REQ-006 a  input  W  operand A, unsigned or two's complement.
REQ-007 b  input  W  operand B.
REQ-008 cin  input  1  carry-in to nibble 0.
REQ-009 out_valid  output  1  result on sum, cout, ovf is valid.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 sum  output  W  registered result (a + b + cin) mod 2^W.
REQ-012 cout  output  1  carry out of bit W-1.
REQ-013 ovf  output  1  signed overflow: carry into bit W-1 XOR carry out of bit W-1.
REQ-014 busy  output  1  high while in ADD state.

Function
REQ-015 The block SHALL implement FSM states IDLE, ADD and DONE.
REQ-016 Input handshake: in_ready SHALL be 1 in IDLE, or in DONE when out_ready=1; it SHALL be 0 in ADD and otherwise in DONE.
REQ-017 An operand set is accepted on an edge where in_valid && in_ready; the block SHALL then capture a, b and cin, clear the nibble index to 0, and enter ADD.
REQ-018 In ADD, each cycle the block SHALL add nibble idx of A and B plus the carry register through one 4-bit carry-lookahead slice.
REQ-019 The slice SHALL compute per-bit g=a&b and p=a^b, with c1..c4 derived in flattened two-level lookahead form from c0 (not rippled).
REQ-020 Each ADD cycle, the block SHALL write the 4-bit slice sum into nibble idx of the result register, load c4 into the carry register, and increment idx.
REQ-021 When idx = NIBBLES-1, the block SHALL go to DONE on that edge, with cout = c4 and ovf = c3 XOR c4 of the final slice.
REQ-022 Latency SHALL be exactly NIBBLES cycles: an operand accepted at edge k gives out_valid=1 after edge k+NIBBLES.
REQ-023 out_valid SHALL be 1 only in DONE, and sum, cout and ovf SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 In DONE, on out_ready=1 with no new accept, the block SHALL go to IDLE and out_valid SHALL drop on that edge.
REQ-025 In DONE, on out_ready=1 together with in_valid=1, the block SHALL complete the output handshake and accept the new operand set on the same edge, going directly to ADD with no idle bubble.
REQ-026 Input changes while not in_ready SHALL have no effect on the operation in progress.
REQ-027 sum, cout and ovf SHALL retain their last values in IDLE and ADD until overwritten, and SHALL be qualified only by out_valid.
REQ-028 The block SHALL be fully wrap-around: 0xFFFF+0x0001 (NIBBLES=4) yields sum 0x0000 with cout=1, and no error condition exists.

Reset
REQ-029 While rst_n=0 at a rising edge, the block SHALL enter IDLE and clear sum, cout, ovf, the carry register and idx to 0; out_valid=0, busy=0, in_ready=1 after that edge.
REQ-030 Reset asserted during ADD or DONE SHALL discard the operation in progress, with no partial result presented.
REQ-031 The first accept SHALL be possible on the first edge with rst_n=1.

Verification (NIBBLES=4)
REQ-032 The bench SHALL cover: a=0x0002, b=0x0003, cin=0 -> after 4 cycles out_valid=1, sum=0x0005, cout=0, ovf=0.
REQ-033 The bench SHALL cover: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; and a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
REQ-034 The bench SHALL cover backpressure: a=0x0C0D, b=0x0D0C; hold out_ready=0 for 3 cycles after out_valid -> sum=0x1919 held stable and in_ready=0 throughout; the result is released when out_ready=1.
REQ-035 The bench SHALL cover back-to-back: in DONE with out_ready=1 and in_valid=1 (a=0x000A, b=0x000B) -> in_ready=1, next result 0x0015 exactly 4 cycles later.
REQ-036 The bench SHALL cover reset mid-operation: rst_n=0 for 1 cycle on the 2nd ADD cycle of a=0x1234, b=0x4321 -> IDLE, sum=0, out_valid stays 0; a new accept completes normally.
REQ-037 Reference-model check: 200 random operand sets with random in_valid/out_ready gaps -> every result equals a+b+cin; no result is lost or duplicated.
